// File: rtl/rtc_port_pkg.sv
`default_nettype none
// ============================================================================
// rtc_port_pkg : shared constants for the PicoBlaze RTC port bank
// Rev 1.0
// ============================================================================
package rtc_port_pkg;

  localparam logic [7:0] DEF_SEL_PORT  = 8'h01;
  localparam logic [7:0] DEF_WR_BASE   = 8'h02;
  localparam logic [7:0] DEF_CTRL_PORT = 8'h0B;
  localparam logic [7:0] DEF_STAT_PORT = 8'h0C;
  localparam logic [7:0] DEF_RD_BASE   = 8'h0D;

  localparam int ST_DONE = 0;
  localparam int ST_SNAP = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_BUSY = 3;

  localparam int CT_GO   = 0;
  localparam int CT_SNAP = 1;

  localparam logic [0:0] FSM_IDLE = 1'b0;
  localparam logic [0:0] FSM_BUSY = 1'b1;

  // True when any two decoded ports collide or a range runs past the 8-bit port space.
  function automatic bit port_map_invalid(input int sel_p, input int ctrl_p, input int stat_p,
                                          input int wr_base, input int n_wr,
                                          input int rd_base, input int n_rd);
    int hits;
    if ((wr_base + n_wr > 256) || (rd_base + n_rd > 256)) return 1'b1;
    for (int p = 0; p < 256; p++) begin
      hits = 0;
      if (p == sel_p)  hits++;
      if (p == ctrl_p) hits++;
      if (p == stat_p) hits++;
      if ((p >= wr_base) && (p < wr_base + n_wr)) hits++;
      if ((p >= rd_base) && (p < rd_base + n_rd)) hits++;
      if (hits > 1) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_edge_sticky.sv
`default_nettype none
// ============================================================================
// rtc_edge_sticky : optional rising-edge detector feeding a sticky flag (set beats clear)
// Rev 1.0
// ============================================================================
module rtc_edge_sticky
  import rtc_port_pkg::*;
#(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  input  logic i_qual,
  input  logic i_clr,
  output logic o_pulse,
  output logic o_flag
);

  logic w_event;
  logic r_flag;

  generate
    if (EDGE) begin : g_edge
      logic r_prev;
      always_ff @(posedge clk) begin
        if (reset) r_prev <= 1'b0;
        else       r_prev <= i_sig;
      end
      assign w_event = i_qual & i_sig & ~r_prev;
    end else begin : g_level
      assign w_event = i_qual & i_sig;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)        r_flag <= 1'b0;
    else if (w_event) r_flag <= 1'b1;
    else if (i_clr)   r_flag <= 1'b0;
  end

  assign o_pulse = w_event;
  assign o_flag  = r_flag;

endmodule
`default_nettype wire

// File: rtl/rtc_port_bank.sv
`default_nettype none
// ============================================================================
// rtc_port_bank : PicoBlaze I/O register bank in front of the RTC transfer controller
// Rev 1.0
// ============================================================================
module rtc_port_bank
  import rtc_port_pkg::*;
#(
  parameter int         DW        = 8,
  parameter int         N_WR      = 9,
  parameter int         N_RD      = 9,
  parameter logic [7:0] SEL_PORT  = DEF_SEL_PORT,
  parameter logic [7:0] WR_BASE   = DEF_WR_BASE,
  parameter logic [7:0] CTRL_PORT = DEF_CTRL_PORT,
  parameter logic [7:0] STAT_PORT = DEF_STAT_PORT,
  parameter logic [7:0] RD_BASE   = DEF_RD_BASE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           port_id,
  input  logic [DW-1:0]        out_port,
  output logic [DW-1:0]        in_port,
  output logic [N_WR*DW-1:0]   wr_fields,
  output logic [N_WR-1:0]      sel_onehot,
  output logic                 go,
  output logic                 busy,
  input  logic [N_RD*DW-1:0]   rd_fields,
  input  logic                 rtc_done
);

  localparam bit c_map_bad = port_map_invalid(int'(SEL_PORT), int'(CTRL_PORT), int'(STAT_PORT),
                                              int'(WR_BASE), N_WR, int'(RD_BASE), N_RD);

  generate
    if (c_map_bad) begin : g_map_check
      $error("rtc_port_bank: port map overlaps or exceeds the 8-bit port space");
    end
    if (N_WR > 2**DW) begin : g_nwr_check
      $error("rtc_port_bank: N_WR exceeds the range of the select index");
    end
    if (DW < 4) begin : g_dw_check
      $error("rtc_port_bank: DW too narrow for the status byte");
    end
  endgenerate

  logic w_ctrl_wr;
  logic w_sel_wr;
  logic w_stat_rd;
  logic w_go_req;
  logic w_snap_req;
  logic w_busy;
  logic w_done_rise;
  logic w_done_flag;
  logic w_err_flag;
  logic w_snap_flag;
  logic w_unused_err_pulse;
  logic w_unused_snap_pulse;
  logic [DW-1:0] w_status;
  logic [DW-1:0] w_rd_data;

  logic [0:0]      r_state;
  logic            r_go;
  logic [DW-1:0]   r_index;
  logic [N_WR-1:0] r_sel;
  logic [DW-1:0]   r_in_port;
  logic [DW-1:0]   r_wr     [N_WR];
  logic [DW-1:0]   r_shadow [N_RD];

  assign w_ctrl_wr  = write_strobe && (port_id == CTRL_PORT);
  assign w_sel_wr   = write_strobe && (port_id == SEL_PORT);
  assign w_stat_rd  = read_strobe  && (port_id == STAT_PORT);
  assign w_go_req   = w_ctrl_wr && out_port[CT_GO];
  assign w_snap_req = w_ctrl_wr && out_port[CT_SNAP];
  assign w_busy     = (r_state == FSM_BUSY);

  generate
    for (genvar gi = 0; gi < N_WR; gi++) begin : g_wr_field
      localparam logic [7:0] c_port = 8'(int'(WR_BASE) + gi);
      always_ff @(posedge clk) begin
        if (reset)                                    r_wr[gi] <= '0;
        else if (write_strobe && (port_id == c_port)) r_wr[gi] <= out_port;
      end
      assign wr_fields[gi*DW +: DW] = r_wr[gi];
    end

    // The shadow is the only source for field reads, so software sees one coherent instant.
    for (genvar gj = 0; gj < N_RD; gj++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (reset)           r_shadow[gj] <= '0;
        else if (w_snap_req) r_shadow[gj] <= rd_fields[gj*DW +: DW];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)         r_index <= '0;
    else if (w_sel_wr) r_index <= out_port;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel <= '0;
    end else begin
      for (int i = 0; i < N_WR; i++) r_sel[i] <= (32'(r_index) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FSM_IDLE;
      r_go    <= 1'b0;
    end else begin
      r_go <= 1'b0;
      case (r_state)
        FSM_IDLE: if (w_go_req) begin
          r_state <= FSM_BUSY;
          r_go    <= 1'b1;
        end
        FSM_BUSY: if (w_done_rise) r_state <= FSM_IDLE;
        default:  r_state <= FSM_IDLE;
      endcase
    end
  end

  rtc_edge_sticky #(.EDGE(1'b1)) u_done (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (rtc_done),
    .i_qual  (w_busy),
    .i_clr   (w_stat_rd),
    .o_pulse (w_done_rise),
    .o_flag  (w_done_flag)
  );

  rtc_edge_sticky #(.EDGE(1'b0)) u_err (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (w_go_req & w_busy),
    .i_qual  (1'b1),
    .i_clr   (w_stat_rd),
    .o_pulse (w_unused_err_pulse),
    .o_flag  (w_err_flag)
  );

  rtc_edge_sticky #(.EDGE(1'b0)) u_snap (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (w_snap_req),
    .i_qual  (1'b1),
    .i_clr   (w_stat_rd),
    .o_pulse (w_unused_snap_pulse),
    .o_flag  (w_snap_flag)
  );

  always_comb begin
    w_status          = '0;
    w_status[ST_DONE] = w_done_flag;
    w_status[ST_SNAP] = w_snap_flag;
    w_status[ST_ERR]  = w_err_flag;
    w_status[ST_BUSY] = w_busy;
  end

  always_comb begin
    w_rd_data = '0;
    if (port_id == STAT_PORT) w_rd_data = w_status;
    for (int i = 0; i < N_RD; i++) begin
      if (port_id == 8'(int'(RD_BASE) + i)) w_rd_data = r_shadow[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_in_port <= '0;
    else       r_in_port <= w_rd_data;
  end

  assign in_port    = r_in_port;
  assign sel_onehot = r_sel;
  assign go         = r_go;
  assign busy       = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_rtc_port_bank.sv
`default_nettype none
// ============================================================================
// tb_rtc_port_bank : randomized scoreboard bench for rtc_port_bank
// Rev 1.0
// ============================================================================
module tb_rtc_port_bank;

  localparam int         DW   = 8;
  localparam int         N_WR = 9;
  localparam int         N_RD = 9;
  localparam logic [7:0] SEL  = 8'h01;
  localparam logic [7:0] WRB  = 8'h02;
  localparam logic [7:0] CTRL = 8'h0B;
  localparam logic [7:0] STAT = 8'h0C;
  localparam logic [7:0] RDB  = 8'h0D;

  logic                clk = 1'b0;
  logic                reset;
  logic                write_strobe;
  logic                read_strobe;
  logic [7:0]          port_id;
  logic [DW-1:0]       out_port;
  logic [DW-1:0]       in_port;
  logic [N_WR*DW-1:0]  wr_fields;
  logic [N_WR-1:0]     sel_onehot;
  logic                go;
  logic                busy;
  logic [N_RD*DW-1:0]  rd_fields;
  logic                rtc_done;

  always #5 clk = ~clk;

  rtc_port_bank #(
    .DW(DW), .N_WR(N_WR), .N_RD(N_RD),
    .SEL_PORT(SEL), .WR_BASE(WRB), .CTRL_PORT(CTRL), .STAT_PORT(STAT), .RD_BASE(RDB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_strobe (write_strobe),
    .read_strobe  (read_strobe),
    .port_id      (port_id),
    .out_port     (out_port),
    .in_port      (in_port),
    .wr_fields    (wr_fields),
    .sel_onehot   (sel_onehot),
    .go           (go),
    .busy         (busy),
    .rd_fields    (rd_fields),
    .rtc_done     (rtc_done)
  );

  typedef struct {
    int                 due;
    logic [7:0]         in_port;
    logic               go;
    logic               busy;
    logic [N_WR-1:0]    sel;
    logic [N_WR*DW-1:0] fields;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: what software would believe the register bank holds.
  logic [7:0]      m_wr [N_WR];
  logic [7:0]      m_sh [N_RD];
  logic [7:0]      m_idx;
  logic            m_busy, m_done, m_err, m_snap, m_prev;
  logic            dl;

  task automatic model_reset();
    for (int i = 0; i < N_WR; i++) m_wr[i] = 8'h00;
    for (int i = 0; i < N_RD; i++) m_sh[i] = 8'h00;
    m_idx = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_snap = 1'b0; m_prev = 1'b0;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] p);
    if (p == STAT) return {4'b0000, m_busy, m_err, m_snap, m_done};
    if ((int'(p) >= int'(RDB)) && (int'(p) < int'(RDB) + N_RD)) return m_sh[int'(p) - int'(RDB)];
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One bus cycle: drive inputs, predict the state after the next edge, queue it.
  task automatic step(input logic rst, input logic ws, input logic rs,
                      input logic [7:0] pid, input logic [7:0] d, input logic done_lvl);
    exp_t e;
    logic set_done, set_err, set_snap, clr, nb, ngo;
    logic [N_WR-1:0] nsel;
    reset = rst; write_strobe = ws; read_strobe = rs; port_id = pid; out_port = d; rtc_done = done_lvl;
    e.due = cyc + 1;
    if (rst) begin
      model_reset();
      e.in_port = 8'h00; e.go = 1'b0; e.busy = 1'b0; e.sel = '0; e.fields = '0;
    end else begin
      e.in_port = model_read(pid);
      for (int i = 0; i < N_WR; i++) nsel[i] = (int'(m_idx) == i);
      set_done = 1'b0; set_err = 1'b0; set_snap = 1'b0; nb = m_busy; ngo = 1'b0;
      clr = rs && (pid == STAT);
      if (ws && (pid == CTRL)) begin
        if (d[1]) begin
          for (int i = 0; i < N_RD; i++) m_sh[i] = rd_fields[i*8 +: 8];
          set_snap = 1'b1;
        end
        if (d[0]) begin
          if (m_busy) set_err = 1'b1;
          else begin ngo = 1'b1; nb = 1'b1; end
        end
      end
      if (m_busy && done_lvl && !m_prev) begin nb = 1'b0; set_done = 1'b1; end
      if (ws && (int'(pid) >= int'(WRB)) && (int'(pid) < int'(WRB) + N_WR)) m_wr[int'(pid) - int'(WRB)] = d;
      if (ws && (pid == SEL)) m_idx = d;
      m_done = set_done | (m_done & ~clr);
      m_err  = set_err  | (m_err  & ~clr);
      m_snap = set_snap | (m_snap & ~clr);
      m_prev = done_lvl;
      m_busy = nb;
      e.go = ngo; e.busy = nb; e.sel = nsel;
      for (int i = 0; i < N_WR; i++) e.fields[i*8 +: 8] = m_wr[i];
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, STAT, 8'h00, dl);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    while ((sb.size() > 0) && (sb[0].due <= cyc)) begin
      mon_e = sb.pop_front();
      if (mon_e.due != cyc) begin
        checks++; errors++;
        $display("FAIL schedule: entry due %0d seen at cycle %0d", mon_e.due, cyc);
      end else begin
        chk("in_port",    128'(in_port),    128'(mon_e.in_port));
        chk("go",         128'(go),         128'(mon_e.go));
        chk("busy",       128'(busy),       128'(mon_e.busy));
        chk("sel_onehot", 128'(sel_onehot), 128'(mon_e.sel));
        chk("wr_fields",  128'(wr_fields),  128'(mon_e.fields));
      end
    end
  end

  initial begin
    logic [7:0] pid, d;
    logic ws, rs, rst;
    reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0; port_id = 8'h00; out_port = 8'h00;
    rtc_done = 1'b0; dl = 1'b0;
    for (int i = 0; i < N_RD; i++) rd_fields[i*8 +: 8] = 8'($urandom);
    model_reset();
    @(posedge clk); #1;
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    idle(2);

    // field write
    step(1'b0, 1'b1, 1'b0, 8'(int'(WRB) + 2), 8'h24, dl);
    idle(1);
    // select register
    step(1'b0, 1'b1, 1'b0, SEL, 8'd8, dl);  idle(2);
    step(1'b0, 1'b1, 1'b0, SEL, 8'd9, dl);  idle(2);
    step(1'b0, 1'b1, 1'b0, SEL, 8'hFF, dl); idle(2);
    // snapshot coherence
    rd_fields[5*8 +: 8] = 8'h59;
    step(1'b0, 1'b1, 1'b0, CTRL, 8'h02, dl);
    rd_fields[5*8 +: 8] = 8'h00;
    step(1'b0, 1'b0, 1'b0, 8'(int'(RDB) + 5), 8'h00, dl);
    step(1'b0, 1'b0, 1'b1, STAT, 8'h00, dl);
    idle(1);
    // GO/BUSY handshake
    step(1'b0, 1'b1, 1'b0, CTRL, 8'h01, dl); idle(1);
    step(1'b0, 1'b1, 1'b0, CTRL, 8'h01, dl); idle(1);
    dl = 1'b1; idle(2);
    step(1'b0, 1'b0, 1'b1, STAT, 8'h00, dl);
    step(1'b0, 1'b0, 1'b1, STAT, 8'h00, dl);
    dl = 1'b0; idle(1);
    // done rising coincident with a status read
    step(1'b0, 1'b1, 1'b0, CTRL, 8'h01, dl); idle(1);
    dl = 1'b1;
    step(1'b0, 1'b0, 1'b1, STAT, 8'h00, dl);
    idle(1);
    step(1'b0, 1'b0, 1'b1, STAT, 8'h00, dl);
    dl = 1'b0; idle(1);
    // reset mid-transfer
    step(1'b0, 1'b1, 1'b0, CTRL, 8'h03, dl); idle(1);
    step(1'b1, 1'b0, 1'b0, STAT, 8'h00, dl);
    step(1'b1, 1'b0, 1'b0, STAT, 8'h00, dl);
    idle(2);

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0:       pid = SEL;
        1:       pid = 8'(int'(WRB) + int'($urandom_range(0, N_WR - 1)));
        2:       pid = CTRL;
        3:       pid = STAT;
        4:       pid = 8'(int'(RDB) + int'($urandom_range(0, N_RD - 1)));
        default: pid = 8'($urandom);
      endcase
      if (pid == CTRL)     d = 8'($urandom_range(0, 3));
      else if (pid == SEL) d = 8'($urandom_range(0, 11));
      else                 d = 8'($urandom);
      ws  = ($urandom_range(0, 1) == 1);
      rs  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) dl = ~dl;
      if ($urandom_range(0, 7) == 0)
        for (int i = 0; i < N_RD; i++) rd_fields[i*8 +: 8] = 8'($urandom);
      step(rst, ws, rs, pid, d, dl);
    end
    idle(2);

    for (int k = 0; (k < 10) && (sb.size() > 0); k++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
